iter_muldiv_alu: RTL and testbench
==================================

# iter_muldiv_alu

Iterative multiply/divide unit for the execute stage, sitting next to the single-cycle ALU and covering the LoongArch MUL/MULH/DIV/MOD word ops that cannot close timing combinationally. It accepts one operation per valid/ready handshake and computes one bit per cycle using shift-add multiplication and restoring division. Results are returned through a valid/ready output handshake. Operand width is a parameter, and a pipeline flush aborts the operation in flight.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 4.
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; dominates all other inputs.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- aluop  in  8  `ALU_MULW`, `ALU_MULHW`, `ALU_MULHWU`, `ALU_DIVW`, `ALU_MODW`, `ALU_DIVWU`, `ALU_MODWU` from defines.vh.
- reg1  in  WIDTH  multiplicand / dividend.
- reg2  in  WIDTH  multiplier / divisor.
- out_valid  out  1  result available (DONE state).
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result; stable while out_valid is high.
- busy  out  1  high in CALC or DONE.

## Operation
- Three states: IDLE, CALC, DONE. A 2-bit state register and a $clog2(WIDTH+1) iteration counter.
- **IDLE**
  - On `in_valid & in_ready & !flush`, latch the op, the operand signs, and the absolute values of the operands.
  - Signed ops (MULW, MULHW, DIVW, MODW) take the two's-complement magnitude. INT_MIN maps to the unsigned value 2^(WIDTH-1).
  - Unsigned ops use the operands unchanged.
  - Next state is CALC with counter = 0.
- **Fast paths** (from IDLE, go directly to DONE):
  - Divide/mod with reg2 == 0:
    - DIVW/DIVWU result = all ones.
    - MODW/MODWU result = reg1.
  - Unrecognised aluop: result = 0.
- **CALC**
  - Multiply: 2·WIDTH-bit accumulator. Each cycle, if multiplier LSB = 1, add the multiplicand shifted by the counter; then shift the multiplier right.
  - Divide: restoring. Each cycle, shift {rem, quo} left by 1; subtract the divisor if the trial difference is ≥ 0 (WIDTH+1-bit subtract); set the quotient LSB accordingly.
  - After exactly WIDTH iterations (counter == WIDTH-1 on the last edge), apply sign correction, write the result register, and go to DONE.
- **Sign correction**
  - Product is negated when the signs differ (signed ops only). MULW returns product[WIDTH-1:0]; MULHW and MULHWU return product[2·WIDTH-1:WIDTH].
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - INT_MIN / -1 yields quotient INT_MIN and remainder 0, with no special case.
- **DONE**
  - out_valid = 1.
  - On `out_ready`, go to IDLE.
  - A new request is never accepted in the same cycle as an output handshake.
- **Flush**
  - In any state, the next edge sets state to IDLE and counter to 0; out_valid falls.
  - A request presented with flush is not accepted.
  - The result register is not required to clear.
- **Reset**
  - state = IDLE, counter = 0, result = 0, out_valid = 0, busy = 0, in_ready = 1.
  - Reset mid-CALC discards the operation immediately (asynchronous).

## Timing
- Accepting handshake in cycle 0: out_valid is high from cycle WIDTH+1 (cycle 33 for WIDTH=32). Fast paths give out_valid in cycle 1.
- out_valid, result, and busy are register outputs. in_ready is decoded from state only, with no combinational path from in_valid, out_ready, or flush.
- out_valid remains high and result remains constant under backpressure (out_ready = 0), for any number of cycles.
- Throughput: one op per WIDTH+2 cycles minimum (accept, WIDTH iterations, one DONE cycle with out_ready = 1).
- flush in the DONE cycle coincident with out_ready: flush wins; the state still goes to IDLE and the consumer must treat the result as discarded.

## Test plan
- MULW 7 × 0xFFFFFFFD → 0xFFFFFFEB, out_valid in cycle 33. MULHWU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHW 0x80000000 × 0x80000000 → 0x40000000.
- DIVW 0xFFFFFFF9 / 2 → 0xFFFFFFFD. MODW same operands → 0xFFFFFFFF. DIVWU 0xFFFFFFF9 / 2 → 0x7FFFFFFC. MODWU → 1.
- DIVWU 5 / 0 → 0xFFFFFFFF in cycle 1. MODW 0xFFFFFFF9 / 0 → 0xFFFFFFF9. DIVW 0x80000000 / 0xFFFFFFFF → 0x80000000. MODW same operands → 0.
- Hold out_ready = 0 for 10 cycles in DONE → out_valid and result stable, in_ready = 0, and an in_valid pulse is ignored. Then out_ready = 1 → IDLE next cycle, and a new op is accepted the cycle after.
- Assert flush in CALC iteration 12 → IDLE next cycle, with no out_valid. The next op (MULW 3 × 5) returns 15 at the normal latency.
- Deassert rstn mid-CALC → outputs immediately take their reset values. Also run randomized compare against a reference model for WIDTH = 32 and WIDTH = 8 across all ops.

Source files
------------

// File: rtl/iter_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : iter_muldiv_alu
// Brief    : Iterative shift-add multiplier / restoring divider with
//            valid/ready handshakes on both sides and pipeline flush.
// Revision : 1.0
// ============================================================================
module iter_muldiv_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       aluop,
  input  logic [WIDTH-1:0] reg1,
  input  logic [WIDTH-1:0] reg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam logic [7:0] c_ALU_MULW   = 8'h10;
  localparam logic [7:0] c_ALU_MULHW  = 8'h11;
  localparam logic [7:0] c_ALU_MULHWU = 8'h12;
  localparam logic [7:0] c_ALU_DIVW   = 8'h13;
  localparam logic [7:0] c_ALU_MODW   = 8'h14;
  localparam logic [7:0] c_ALU_DIVWU  = 8'h15;
  localparam logic [7:0] c_ALU_MODWU  = 8'h16;

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [7:0]           r_op;
  logic                 r_neg_xor, r_neg_rem;
  logic [2*WIDTH-1:0]   r_mcand, r_acc;
  logic [WIDTH-1:0]     r_mplier, r_divisor, r_quo, r_rem;
  logic [WIDTH-1:0]     r_result, w_result_nxt;
  logic                 r_out_valid, r_busy;
  logic                 w_load, w_res_we;

  logic                 w_is_mul, w_is_div, w_is_signed, w_is_quo_op;
  logic [WIDTH-1:0]     w_abs1, w_abs2;
  logic [2*WIDTH-1:0]   w_acc_nxt, w_prod;
  logic [WIDTH:0]       w_shift;
  logic                 w_fits;
  logic [WIDTH-1:0]     w_rem_nxt, w_quo_nxt, w_quo_fix, w_rem_fix, w_final;

  assign w_is_mul    = (aluop == c_ALU_MULW) || (aluop == c_ALU_MULHW) || (aluop == c_ALU_MULHWU);
  assign w_is_div    = (aluop == c_ALU_DIVW) || (aluop == c_ALU_MODW)
                    || (aluop == c_ALU_DIVWU) || (aluop == c_ALU_MODWU);
  assign w_is_signed = (aluop == c_ALU_MULW) || (aluop == c_ALU_MULHW)
                    || (aluop == c_ALU_DIVW) || (aluop == c_ALU_MODW);
  assign w_is_quo_op = (aluop == c_ALU_DIVW) || (aluop == c_ALU_DIVWU);

  // INT_MIN negates to itself, which read as unsigned is exactly 2^(WIDTH-1)
  assign w_abs1 = (w_is_signed && reg1[WIDTH-1]) ? -reg1 : reg1;
  assign w_abs2 = (w_is_signed && reg2[WIDTH-1]) ? -reg2 : reg2;

  // One multiply step and one restoring-divide step per cycle
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_fits    = (w_shift >= {1'b0, r_divisor});
  assign w_rem_nxt = w_fits ? (w_shift[WIDTH-1:0] - r_divisor) : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_fits};

  assign w_prod    = r_neg_xor ? -w_acc_nxt : w_acc_nxt;
  assign w_quo_fix = r_neg_xor ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix = r_neg_rem ? -w_rem_nxt : w_rem_nxt;

  always_comb begin
    w_final = '0;
    case (r_op)
      c_ALU_MULW:                w_final = w_prod[WIDTH-1:0];
      c_ALU_MULHW, c_ALU_MULHWU: w_final = w_prod[2*WIDTH-1:WIDTH];
      c_ALU_DIVW, c_ALU_DIVWU:   w_final = w_quo_fix;
      c_ALU_MODW, c_ALU_MODWU:   w_final = w_rem_fix;
      default:                   w_final = '0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_load       = 1'b0;
    w_res_we     = 1'b0;
    w_result_nxt = r_result;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_load = 1'b1;
          if (!(w_is_mul || w_is_div)) begin
            w_state_nxt  = S_DONE;
            w_res_we     = 1'b1;
            w_result_nxt = '0;
          end else if (w_is_div && (reg2 == '0)) begin
            w_state_nxt  = S_DONE;
            w_res_we     = 1'b1;
            w_result_nxt = w_is_quo_op ? '1 : reg1;
          end else begin
            w_state_nxt = S_CALC;
            w_cnt_nxt   = '0;
          end
        end
      end
      S_CALC: begin
        if (r_cnt == c_LAST) begin
          w_state_nxt  = S_DONE;
          w_cnt_nxt    = '0;
          w_res_we     = 1'b1;
          w_result_nxt = w_final;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_load      = 1'b0;
      w_res_we    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
      if (w_res_we) begin
        r_result <= w_result_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op      <= '0;
      r_neg_xor <= 1'b0;
      r_neg_rem <= 1'b0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_divisor <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
    end else if (w_load) begin
      r_op      <= aluop;
      r_neg_xor <= w_is_signed & (reg1[WIDTH-1] ^ reg2[WIDTH-1]);
      r_neg_rem <= w_is_signed & reg1[WIDTH-1];
      r_mcand   <= {{WIDTH{1'b0}}, w_abs1};
      r_acc     <= '0;
      r_mplier  <= w_abs2;
      r_divisor <= w_abs2;
      r_quo     <= w_abs1;
      r_rem     <= '0;
    end else if (r_state == S_CALC) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_quo    <= w_quo_nxt;
      r_rem    <= w_rem_nxt;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_iter_muldiv_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_iter_muldiv_alu
// Brief    : Random + directed checking of iter_muldiv_alu at WIDTH 32 and 8.
// Revision : 1.0
// ============================================================================
module tb_iter_muldiv_alu;

  localparam logic [7:0] ALU_MULW   = 8'h10;
  localparam logic [7:0] ALU_MULHW  = 8'h11;
  localparam logic [7:0] ALU_MULHWU = 8'h12;
  localparam logic [7:0] ALU_DIVW   = 8'h13;
  localparam logic [7:0] ALU_MODW   = 8'h14;
  localparam logic [7:0] ALU_DIVWU  = 8'h15;
  localparam logic [7:0] ALU_MODWU  = 8'h16;
  localparam logic [7:0] ALU_BAD    = 8'hA5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2, result;

  logic        rstn8, flush8, in_valid8, in_ready8, out_valid8, out_ready8, busy8;
  logic [7:0]  aluop8, reg1_8, reg2_8, result8;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  done8    = 1'b0;
  longint unsigned q32[$];
  longint unsigned q8[$];

  iter_muldiv_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .reg1(reg1), .reg2(reg2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  iter_muldiv_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rstn(rstn8), .flush(flush8), .in_valid(in_valid8), .in_ready(in_ready8),
    .aluop(aluop8), .reg1(reg1_8), .reg2(reg2_8), .out_valid(out_valid8),
    .out_ready(out_ready8), .result(result8), .busy(busy8)
  );

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on wide integers
  function automatic longint unsigned model(input logic [7:0] op, input longint unsigned a,
                                            input longint unsigned b, input int w);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    longint sa, sb, p;
    longint unsigned pu;
    sa = a[w-1] ? $signed(a - (64'd1 << w)) : $signed(a);
    sb = b[w-1] ? $signed(b - (64'd1 << w)) : $signed(b);
    p  = sa * sb;
    pu = a * b;
    case (op)
      ALU_MULW:   return $unsigned(p) & mask;
      ALU_MULHW:  return $unsigned(p >>> w) & mask;
      ALU_MULHWU: return (pu >> w) & mask;
      ALU_DIVW:   begin if (b == 0) return mask; return $unsigned(sa / sb) & mask; end
      ALU_MODW:   begin if (b == 0) return a;    return $unsigned(sa % sb) & mask; end
      ALU_DIVWU:  begin if (b == 0) return mask; return a / b; end
      ALU_MODWU:  begin if (b == 0) return a;    return a % b; end
      default:    return 0;
    endcase
  endfunction

  function automatic bit is_fast(input logic [7:0] op, input longint unsigned b);
    bit is_mul = (op == ALU_MULW) || (op == ALU_MULHW) || (op == ALU_MULHWU);
    bit is_div = (op == ALU_DIVW) || (op == ALU_MODW) || (op == ALU_DIVWU) || (op == ALU_MODWU);
    return !(is_mul || is_div) || (is_div && b == 0);
  endfunction

  function automatic longint unsigned rnd_val(input int w);
    longint unsigned mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return 1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  function automatic logic [7:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return ALU_MULW;
      1: return ALU_MULHW;
      2: return ALU_MULHWU;
      3: return ALU_DIVW;
      4: return ALU_MODW;
      5: return ALU_DIVWU;
      6: return ALU_MODWU;
      default: return ALU_BAD;
    endcase
  endfunction

  // Compare processes: every cycle with out_valid the result must match the model head
  always @(negedge clk) begin
    if (rstn) begin
      check("in_ready_vs_busy32", in_ready, !busy);
      if (out_valid) begin
        n_checks++;
        if (q32.size() == 0) begin
          n_fail++;
          $display("FAIL valid32_without_request: actual out_valid=1 required=0");
        end else begin
          if (result !== q32[0][31:0]) begin
            n_fail++;
            $display("FAIL result32: actual=%0h required=%0h", result, q32[0]);
          end
          if (out_ready) void'(q32.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn8) begin
      check("in_ready_vs_busy8", in_ready8, !busy8);
      if (out_valid8) begin
        n_checks++;
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL valid8_without_request: actual out_valid=1 required=0");
        end else begin
          if (result8 !== q8[0][7:0]) begin
            n_fail++;
            $display("FAIL result8: actual=%0h required=%0h", result8, q8[0]);
          end
          if (out_ready8) void'(q8.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle
  task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int hold, output logic [31:0] res);
    int lat;
    check("in_ready_before_op32", in_ready, 1);
    aluop = op; reg1 = a; reg2 = b; in_valid = 1'b1;
    @(posedge clk);
    q32.push_back(model(op, a, b, 32));
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("latency32", lat, is_fast(op, b) ? 1 : 33);
    res = result;
    for (int i = 0; i < hold; i++) begin
      check("hold_valid32", out_valid, 1);
      check("hold_in_ready32", in_ready, 0);
      in_valid = (i == 0); aluop = ALU_MULW; reg1 = $urandom; reg2 = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("idle_busy32", busy, 0);
    check("idle_valid32", out_valid, 0);
  endtask

  task automatic do_op8(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int hold);
    int lat;
    check("in_ready_before_op8", in_ready8, 1);
    aluop8 = op; reg1_8 = a; reg2_8 = b; in_valid8 = 1'b1;
    @(posedge clk);
    q8.push_back(model(op, a, b, 8));
    #1 in_valid8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("latency8", lat, is_fast(op, b) ? 1 : 9);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid8", out_valid8, 1);
      in_valid8 = (i == 0); aluop8 = ALU_DIVW; reg1_8 = 8'($urandom); reg2_8 = 8'd3;
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(posedge clk); #1 out_ready8 = 1'b0;
    check("idle_busy8", busy8, 0);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11] = '{
    '{ALU_MULW,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB},
    '{ALU_MULHWU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
    '{ALU_MULHW,  32'h80000000, 32'h80000000, 32'h40000000},
    '{ALU_DIVW,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD},
    '{ALU_MODW,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF},
    '{ALU_DIVWU,  32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC},
    '{ALU_MODWU,  32'hFFFFFFF9, 32'd2,        32'h00000001},
    '{ALU_DIVWU,  32'd5,        32'd0,        32'hFFFFFFFF},
    '{ALU_MODW,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9},
    '{ALU_DIVW,   32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{ALU_MODW,   32'h80000000, 32'hFFFFFFFF, 32'h00000000}
  };

  initial begin
    rstn8 = 1'b0; flush8 = 1'b0; in_valid8 = 1'b0; out_ready8 = 1'b0;
    aluop8 = '0; reg1_8 = '0; reg2_8 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset8_result", result8, 0);
    check("reset8_valid", out_valid8, 0);
    rstn8 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      logic [7:0] op8;
      op8 = rnd_op();
      do_op8(op8, 8'(rnd_val(8)), 8'(rnd_val(8)), $urandom_range(0, 2));
    end
    done8 = 1'b1;
  end

  initial begin
    logic [31:0] res;
    int          lat;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    aluop = '0; reg1 = '0; reg2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_in_ready", in_ready, 1);
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res);
      check($sformatf("directed_%0d", i), res, vecs[i].exp);
    end

    // Backpressure for 10 cycles, then an immediate follow-on op
    do_op(ALU_DIVWU, 32'd100, 32'd7, 10, res);
    check("backpressure_result", res, 14);
    do_op(ALU_MODWU, 32'd100, 32'd7, 0, res);
    check("after_backpressure", res, 2);

    // Flush at iteration 12, then a flushed request in IDLE
    aluop = ALU_MULW; reg1 = 32'd123; reg2 = 32'd456; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_valid", out_valid, 0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    do_op(ALU_MULW, 32'd3, 32'd5, 0, res);
    check("after_flush_mulw", res, 15);

    // Flush coinciding with the output handshake
    aluop = ALU_MULW; reg1 = 32'd2; reg2 = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    q32.push_back(model(ALU_MULW, 32'd2, 32'd3, 32));
    #1 in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("flush_done_latency", lat, 33);
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0; flush = 1'b0;
    check("flush_done_busy", busy, 0);
    check("flush_done_valid", out_valid, 0);

    // Asynchronous reset in the middle of CALC
    aluop = ALU_MULHWU; reg1 = 32'hDEADBEEF; reg2 = 32'h12345678; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_in_ready", in_ready, 1);
    check("async_rst_result", result, 0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    for (int n = 0; n < 60; n++) begin
      logic [7:0] op;
      op = rnd_op();
      do_op(op, 32'(rnd_val(32)), 32'(rnd_val(32)), $urandom_range(0, 2), res);
    end

    for (int i = 0; i < 20000 && !done8; i++) @(posedge clk);
    if (!done8) begin
      n_checks++;
      n_fail++;
      $display("FAIL width8_timeout: actual done=0 required=1");
    end
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
